// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath: enables, selects, round, Rcon, done.
// Optional macro AES_CTRL_RESTART_EN: a load fall while busy or done restarts encryption.
module aes_round_ctrl #(
  parameter int SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       state_en,
  output logic       state_sel,
  output logic       key_en,
  output logic       key_sel,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       skip_mix,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, INIT, SUB, UPD, DONE} state_t;

  localparam logic [1:0] WAIT_LAST = (SBOX_LAT > 0) ? 2'(SBOX_LAT - 1) : 2'd0;
  localparam bit         NO_WAIT   = (SBOX_LAT == 0);

  state_t     state, state_next;
  logic       load_q;
  logic [3:0] round_q, round_next;
  logic [1:0] wait_q, wait_next;
  logic       start, rise;

  assign start = load_q & ~load;
  assign rise  = ~load_q & load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      round_q <= 4'd0;
      wait_q  <= 2'd0;
      load_q  <= 1'b0;
    end else begin
      state   <= state_next;
      round_q <= round_next;
      wait_q  <= wait_next;
      load_q  <= load;
    end
  end

  always_comb begin
    state_next = state;
    round_next = round_q;
    wait_next  = wait_q;
    state_en   = 1'b0;
    state_sel  = 1'b0;
    key_en     = 1'b0;
    key_sel    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = INIT;
          round_next = 4'd0;
        end
      end
      INIT: begin
        state_en   = 1'b1;
        key_en     = 1'b1;
        busy       = 1'b1;
        round_next = 4'd1;
        wait_next  = 2'd0;
        state_next = NO_WAIT ? UPD : SUB;
      end
      SUB: begin
        // Hold everything while the synchronous sbox output settles.
        busy = 1'b1;
        if (wait_q == WAIT_LAST) begin
          state_next = UPD;
          wait_next  = 2'd0;
        end else begin
          wait_next = wait_q + 2'd1;
        end
      end
      UPD: begin
        state_en  = 1'b1;
        state_sel = 1'b1;
        key_en    = 1'b1;
        key_sel   = 1'b1;
        busy      = 1'b1;
        if (round_q == 4'd10) begin
          state_next = DONE;
        end else begin
          round_next = round_q + 4'd1;
          wait_next  = 2'd0;
          state_next = NO_WAIT ? UPD : SUB;
        end
      end
      DONE: begin
        done = 1'b1;
        if (rise) begin
          state_next = IDLE;
          round_next = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
        round_next = 4'd0;
        wait_next  = 2'd0;
      end
    endcase
`ifdef AES_CTRL_RESTART_EN
    if (start && state != IDLE) begin
      state_next = INIT;
      round_next = 4'd0;
      wait_next  = 2'd0;
    end
`endif
  end

  assign round    = round_q;
  assign skip_mix = (state == SUB || state == UPD) && (round_q == 4'd10);

  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: timeline model checked every cycle plus literal latency/pulse/Rcon checks.
module tb_aes_round_ctrl;

  localparam int SBOX_LAT  = 1;
  localparam int ROUND_LEN = SBOX_LAT + 1;
  localparam int LAST_K    = 1 + 10 * ROUND_LEN;
  localparam int DONE_LAT  = 2 + 10 * ROUND_LEN;
  localparam int BOUND     = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b1;
  logic       state_en, state_sel, key_en, key_sel, skip_mix, busy, done;
  logic [3:0] round;
  logic [7:0] rcon;

  always #5 clk = ~clk;

  aes_round_ctrl #(.SBOX_LAT(SBOX_LAT)) dut (
    .clk(clk), .reset(reset), .load(load),
    .state_en(state_en), .state_sel(state_sel), .key_en(key_en), .key_sel(key_sel),
    .round(round), .rcon(rcon), .skip_mix(skip_mix), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an encryption is a timeline indexed by cycles since the start was seen.
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_k = 0;
  logic       m_loadq = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] rcon_tab [0:10];

  initial begin
    rcon_tab[0] = 8'h00;
    rcon_tab[1] = 8'h01;
    for (int i = 2; i <= 10; i++)
      rcon_tab[i] = rcon_tab[i-1][7] ? ((rcon_tab[i-1] << 1) ^ 8'h1b) : (rcon_tab[i-1] << 1);
  end

  always @(posedge clk) begin : model
    logic st, rs;
    st = m_loadq & ~load;
    rs = ~m_loadq & load;
    if (reset) begin
      m_mode  <= M_IDLE;
      m_k     <= 0;
      m_loadq <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_loadq <= load;
      case (m_mode)
        M_IDLE: if (st) begin m_mode <= M_RUN; m_k <= 1; end
        M_RUN: begin
`ifdef AES_CTRL_RESTART_EN
          if (st) m_k <= 1;
          else
`endif
          if (m_k == LAST_K) m_mode <= M_DONE;
          else m_k <= m_k + 1;
        end
        default: begin
`ifdef AES_CTRL_RESTART_EN
          if (st) begin m_mode <= M_RUN; m_k <= 1; end
          else
`endif
          if (rs) m_mode <= M_IDLE;
        end
      endcase
    end
  end

  int         se_count = 0, ke_count = 0, skip_count = 0;
  logic [7:0] rcon_log [$];

  always @(negedge clk) begin : compare
    int r, ph;
    logic upd, e_en, e_sel, e_skip, e_busy, e_done;
    logic [3:0] e_round;
    logic [7:0] e_rcon;
    if (m_valid) begin
      e_en = 0; e_sel = 0; e_skip = 0; e_busy = 0; e_done = 0; e_round = 0; e_rcon = 0;
      if (m_mode == M_RUN) begin
        e_busy = 1;
        if (m_k == 1) begin
          e_en = 1;
        end else begin
          r   = (m_k - 2) / ROUND_LEN + 1;
          ph  = (m_k - 2) % ROUND_LEN;
          upd = (ph == SBOX_LAT);
          e_en = upd; e_sel = upd;
          e_round = 4'(r); e_rcon = rcon_tab[r]; e_skip = (r == 10);
        end
      end else if (m_mode == M_DONE) begin
        e_done = 1; e_round = 4'd10; e_rcon = rcon_tab[10];
      end
      check_output("state_en", state_en, e_en);
      check_output("key_en", key_en, e_en);
      if (e_en) begin
        check_output("state_sel", state_sel, e_sel);
        check_output("key_sel", key_sel, e_sel);
      end
      check_output("round", round, e_round);
      check_output("rcon", rcon, e_rcon);
      check_output("skip_mix", skip_mix, e_skip);
      check_output("busy", busy, e_busy);
      check_output("done", done, e_done);
      if (state_en) se_count++;
      if (key_en) ke_count++;
      if (skip_mix) skip_count++;
      if (state_en && state_sel) rcon_log.push_back(rcon);
    end
  end

  // Raise load for a cycle, clear the run counters, then drop load; c0 is the cycle stamp of the drop.
  task automatic apply_stimulus(output int c0);
    @(negedge clk) load = 1'b1;
    @(posedge clk);
    #1;
    se_count = 0; ke_count = 0; skip_count = 0;
    rcon_log.delete();
    @(negedge clk) load = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - c0;
        return;
      end
    end
    check_output("done_timeout", 0, 1);
  endtask

  task automatic wait_round(input int r);
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk);
      #1;
      if (round == 4'(r)) return;
    end
    check_output("round_timeout", 0, r);
  endtask

  task automatic check_run(input int lat);
    logic [7:0] exp_rcon [0:9];
    exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    check_output("done_latency", lat, DONE_LAT);
    check_output("state_en_pulses", se_count, 11);
    check_output("key_en_pulses", ke_count, 11);
    check_output("skip_mix_cycles", skip_count, ROUND_LEN);
    check_output("rcon_log_size", rcon_log.size(), 10);
    for (int i = 0; i < 10 && i < rcon_log.size(); i++)
      check_output($sformatf("rcon_upd%0d", i + 1), rcon_log[i], exp_rcon[i]);
  endtask

  initial begin
    int c0, c_fall, lat;
    reset = 1'b1;
    load  = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] reset held with load=1");
    check_output("reset_state_en", state_en, 0);
    check_output("reset_state_sel", state_sel, 0);
    check_output("reset_key_en", key_en, 0);
    check_output("reset_key_sel", key_sel, 0);
    check_output("reset_round", round, 0);
    check_output("reset_rcon", rcon, 0);
    check_output("reset_skip_mix", skip_mix, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    reset = 1'b0;

    $display("[TB] full encryption");
    apply_stimulus(c0);
    wait_done(c0, lat);
    check_run(lat);
    repeat (3) @(negedge clk);

    $display("[TB] reset during round 5");
    apply_stimulus(c0);
    wait_round(5);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    #1;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_round", round, 0);
    apply_stimulus(c0);
    wait_done(c0, lat);
    check_run(lat);

    $display("[TB] load pulse during round 3");
    apply_stimulus(c0);
    wait_round(3);
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    c_fall = cyc;
    wait_done(c0, lat);
`ifdef AES_CTRL_RESTART_EN
    check_output("restart_latency", lat - (c_fall - c0), DONE_LAT);
`else
    check_run(lat);
`endif
    repeat (4) @(negedge clk);

    $display("[TB] rise from done, then idle with load high");
    @(negedge clk) load = 1'b1;
    repeat (5) @(negedge clk);
    check_output("idle_after_rise", busy | done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
